qos_classifier: RTL and testbench
=================================

QOS_CLASSIFIER -- requirements
Module: qos_classifier

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, width of data words.
REQ-002 SHALL have parameter QUEUE_QUANTITY, default 4, number of downstream FIFO queues (class field = data_in[DATA_BITS-1 -: 2]).
REQ-003 SHALL have parameter DROP_ON_FULL, default 0, where 0 means stall on full queue and 1 means drop.
REQ-004 SHALL have parameter CNT_BITS, default 8, width of each statistics counter.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL have these ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  synchronous active-high reset.
- data_in  input  DATA_BITS  incoming word, class in top 2 bits.
- valid_in  input  1  data_in valid.
- ready_out  output  1  block can accept data_in this cycle.
- fifo_full  input  QUEUE_QUANTITY  per-queue full flag from the FIFO bank.
- fifo_data  output  DATA_BITS  word presented to all queues.
- fifo_wr_en  output  QUEUE_QUANTITY  one-hot write enable, bit = class.
- pass_count  output  QUEUE_QUANTITY*CNT_BITS  per-class written-word counters, class 0 in the LSBs.
- drop_count  output  CNT_BITS  total dropped words.

Function
REQ-007 SHALL hold one entry in a register, with state EMPTY or HELD, plus held_data and held_class.
REQ-008 SHALL accept a word at a rising edge when valid_in=1 and ready_out=1, and capture it into the hold register with state HELD.
REQ-009 SHALL drive fifo_data = held_data whenever the state is HELD; fifo_data value is don't-care when EMPTY.
REQ-010 SHALL assert fifo_wr_en[held_class] combinationally when HELD and fifo_full[held_class]=0, with all other bits at 0.
REQ-011 SHALL hold fifo_wr_en at all zeros when EMPTY or when the target queue is full.
REQ-012 SHALL give a latency of 1 cycle, with the word accepted at edge N and written at edge N+1 if its queue is not full.
REQ-013 SHALL drive ready_out as follows, with DROP_ON_FULL=0: ready_out = EMPTY or (HELD and fifo_full[held_class]=0), combinational, which sustains 1 word/cycle.
REQ-014 SHALL keep held_data stable while stalled (DROP_ON_FULL=0, HELD, target full) until the queue frees, with no loss.
REQ-015 SHALL keep ready_out=1 outside reset when DROP_ON_FULL=1; if HELD with target full at an edge, the held word is discarded, drop_count increments, and the hold register takes the new word if one is accepted, else goes EMPTY.
REQ-016 SHALL handle the HELD state at each edge as follows:
- write done and no new word accepted -> EMPTY.
- write done and new word accepted -> remains HELD with the new word.
REQ-017 SHALL increment pass_count[class] on every edge where fifo_wr_en[class]=1.
REQ-018 SHALL saturate all counters at 2^CNT_BITS-1 with no wrap-around.
REQ-019 SHALL make full flags on non-target queues irrelevant, with no effect on ready_out or writes.
REQ-020 SHALL evaluate ready_out on the same cycle as the last-slot write when fifo_full[held_class] rises, without a one-cycle bubble.

Reset
REQ-021 SHALL, while reset=1 at a rising edge, set the state to EMPTY, clear held_data and held_class to 0, and clear all pass_count and drop_count to 0.
REQ-022 SHALL drive ready_out=0 and fifo_wr_en=0 during any cycle with reset=1.
REQ-023 SHALL discard a held word on reset mid-operation, without counting it as dropped.
REQ-024 SHALL drive ready_out=1 on the first cycle after reset deasserts.

Verification
REQ-025 SHALL cover the basic route case: reset, then data_in=8'h85 (class 2) valid 1 cycle -> next cycle fifo_wr_en=4'b0100, fifo_data=8'h85, then pass_count class 2 = 1.
REQ-026 SHALL cover streaming: 8 back-to-back words, classes 0,1,2,3,0,1,2,3, all queues not full -> ready_out stays 1, one write per cycle, each pass_count = 2.
REQ-027 SHALL cover stall with DROP_ON_FULL=0: fifo_full[1]=1, send 8'h4A -> fifo_wr_en=0, ready_out=0 for 3 cycles; deassert full -> 8'h4A written once, ready_out=1.
REQ-028 SHALL cover drop with DROP_ON_FULL=1: fifo_full[3]=1, send 8'hC0 then 8'h01 -> 8'hC0 not written, drop_count=1, 8'h01 written to queue 0.
REQ-029 SHALL cover saturation: 300 class-0 words, queues not full -> pass_count class 0 = 255, other counts 0.
REQ-030 SHALL cover reset mid-operation: HELD stalled word, assert reset 1 cycle -> no write, all counters 0, ready_out=1 next cycle.

Source files
------------

// File: rtl/qos_classifier.sv
`default_nettype none
// ============================================================================
// Module   : qos_classifier
// Purpose  : one-entry hold register routing words to per-class FIFO queues
//            with stall-or-drop on full and saturating statistics counters.
// Revision : 1.0
// ============================================================================
module qos_classifier #(
  parameter int DATA_BITS      = 8,
  parameter int QUEUE_QUANTITY = 4,
  parameter bit DROP_ON_FULL   = 1'b0,
  parameter int CNT_BITS       = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [DATA_BITS-1:0]               data_in,
  input  logic                               valid_in,
  output logic                               ready_out,
  input  logic [QUEUE_QUANTITY-1:0]          fifo_full,
  output logic [DATA_BITS-1:0]               fifo_data,
  output logic [QUEUE_QUANTITY-1:0]          fifo_wr_en,
  output logic [QUEUE_QUANTITY*CNT_BITS-1:0] pass_count,
  output logic [CNT_BITS-1:0]                drop_count
);

  localparam int                NUM_CLASSES = 4;
  localparam logic [CNT_BITS-1:0] CNT_MAX   = '1;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] held_data_q, held_data_d;
  logic [1:0]           held_class_q, held_class_d;
  logic [CNT_BITS-1:0]  pass_q [QUEUE_QUANTITY];
  logic [CNT_BITS-1:0]  pass_d [QUEUE_QUANTITY];
  logic [CNT_BITS-1:0]  drop_q, drop_d;

  logic [NUM_CLASSES-1:0] full_by_class;
  logic                   target_full;
  logic                   write_w;
  logic                   drop_w;
  logic                   accept_w;

  // Classes with no backing queue look permanently full, so they stall or drop.
  for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_full
    if (c < QUEUE_QUANTITY) begin : g_real
      assign full_by_class[c] = fifo_full[c];
    end else begin : g_absent
      assign full_by_class[c] = 1'b1;
    end
  end

  assign target_full = full_by_class[held_class_q];
  assign write_w     = !reset && (state_q == HELD) && !target_full;
  assign drop_w      = DROP_ON_FULL && !reset && (state_q == HELD) && target_full;

  always_comb begin
    ready_out = 1'b0;
    if (!reset) begin
      if (DROP_ON_FULL) begin
        ready_out = 1'b1;
      end else begin
        ready_out = (state_q == EMPTY) || !target_full;
      end
    end
  end

  assign accept_w = valid_in && ready_out;

  for (genvar q = 0; q < QUEUE_QUANTITY; q++) begin : g_wr
    if (q < NUM_CLASSES) begin : g_route
      assign fifo_wr_en[q] = write_w && (held_class_q == 2'(q));
    end else begin : g_unused
      assign fifo_wr_en[q] = 1'b0;
    end
    assign pass_count[q*CNT_BITS +: CNT_BITS] = pass_q[q];
  end

  assign fifo_data  = held_data_q;
  assign drop_count = drop_q;

  // A departing word (written or dropped) frees the slot for a word accepted
  // on the same edge, which keeps the path at one word per cycle.
  always_comb begin
    state_d      = state_q;
    held_data_d  = held_data_q;
    held_class_d = held_class_q;
    if (accept_w) begin
      state_d      = HELD;
      held_data_d  = data_in;
      held_class_d = data_in[DATA_BITS-1 -: 2];
    end else if (write_w || drop_w) begin
      state_d = EMPTY;
    end
  end

  always_comb begin
    for (int q = 0; q < QUEUE_QUANTITY; q++) begin
      pass_d[q] = pass_q[q];
      if (fifo_wr_en[q] && (pass_q[q] != CNT_MAX)) begin
        pass_d[q] = pass_q[q] + CNT_BITS'(1);
      end
    end
    drop_d = drop_q;
    if (drop_w && (drop_q != CNT_MAX)) begin
      drop_d = drop_q + CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= EMPTY;
      held_data_q  <= '0;
      held_class_q <= '0;
      for (int q = 0; q < QUEUE_QUANTITY; q++) begin
        pass_q[q] <= '0;
      end
      drop_q <= '0;
    end else begin
      state_q      <= state_d;
      held_data_q  <= held_data_d;
      held_class_q <= held_class_d;
      for (int q = 0; q < QUEUE_QUANTITY; q++) begin
        pass_q[q] <= pass_d[q];
      end
      drop_q <= drop_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_qos_classifier.sv
`default_nettype none
// ============================================================================
// Module   : tb_qos_classifier
// Purpose  : checks a stalling and a dropping classifier side by side.
// Revision : 1.0
// ============================================================================
module tb_qos_classifier;

  logic        clk;
  logic        reset;
  logic [7:0]  data_in;
  logic        valid_in;
  logic [3:0]  fifo_full;

  logic        rdy      [2];
  logic [7:0]  fdata    [2];
  logic [3:0]  wr_en    [2];
  logic [31:0] pcount   [2];
  logic [7:0]  dcount   [2];

  int total;
  int bad;

  qos_classifier #(
    .DATA_BITS(8), .QUEUE_QUANTITY(4), .DROP_ON_FULL(1'b0), .CNT_BITS(8)
  ) dut_stall (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .ready_out(rdy[0]), .fifo_full(fifo_full), .fifo_data(fdata[0]),
    .fifo_wr_en(wr_en[0]), .pass_count(pcount[0]), .drop_count(dcount[0])
  );

  qos_classifier #(
    .DATA_BITS(8), .QUEUE_QUANTITY(4), .DROP_ON_FULL(1'b1), .CNT_BITS(8)
  ) dut_drop (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .ready_out(rdy[1]), .fifo_full(fifo_full), .fifo_data(fdata[1]),
    .fifo_wr_en(wr_en[1]), .pass_count(pcount[1]), .drop_count(dcount[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a one-word slot per variant, counters as plain integers.
  bit         m_held [2];
  logic [7:0] m_data [2];
  int         m_cls  [2];
  int         m_pass [2][4];
  int         m_drop [2];

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      bit          tf;
      bit          wr;
      bit          erdy;
      bit          acc;
      logic [3:0]  ewr;
      logic [31:0] epass;
      tf    = m_held[m] && fifo_full[m_cls[m]];
      wr    = !reset && m_held[m] && !tf;
      ewr   = wr ? (4'b0001 << m_cls[m]) : 4'b0000;
      erdy  = reset ? 1'b0 : ((m == 1) ? 1'b1 : !tf);
      for (int c = 0; c < 4; c++) epass[8*c +: 8] = 8'(m_pass[m][c]);
      check($sformatf("model ready[%0d]", m), 32'(rdy[m]), 32'(erdy));
      check($sformatf("model wr_en[%0d]", m), 32'(wr_en[m]), 32'(ewr));
      check($sformatf("model pass[%0d]", m), pcount[m], epass);
      check($sformatf("model drop[%0d]", m), 32'(dcount[m]), 32'(m_drop[m]));
      if (!reset && m_held[m]) check($sformatf("model data[%0d]", m), 32'(fdata[m]), 32'(m_data[m]));
      // advance the model to the state after the coming rising edge
      acc = valid_in && erdy;
      if (reset) begin
        m_held[m] = 1'b0;
        m_drop[m] = 0;
        for (int c = 0; c < 4; c++) m_pass[m][c] = 0;
      end else begin
        if (wr && m_pass[m][m_cls[m]] < 255) m_pass[m][m_cls[m]]++;
        if (m == 1 && m_held[m] && tf && m_drop[m] < 255) m_drop[m]++;
        if (acc) begin
          m_held[m] = 1'b1;
          m_data[m] = data_in;
          m_cls[m]  = int'(data_in[7:6]);
        end else if (wr || (m == 1 && tf)) begin
          m_held[m] = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    total = 0; bad = 0;
    for (int m = 0; m < 2; m++) begin
      m_held[m] = 1'b0; m_data[m] = 8'h00; m_cls[m] = 0; m_drop[m] = 0;
      for (int c = 0; c < 4; c++) m_pass[m][c] = 0;
    end
    reset = 1'b1; valid_in = 1'b0; data_in = 8'h00; fifo_full = 4'b0000;
    step();
    settle();
    check("reset ready", 32'(rdy[0]), 32'd0);
    check("reset wr_en", 32'(wr_en[1]), 32'd0);
    step();
    reset = 1'b0;
    settle();
    check("post-reset ready stall", 32'(rdy[0]), 32'd1);
    check("post-reset ready drop", 32'(rdy[1]), 32'd1);
    check("post-reset pass", pcount[0], 32'h0);

    // basic route
    data_in = 8'h85; valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    settle();
    check("route wr_en", 32'(wr_en[0]), 32'h4);
    check("route data", 32'(fdata[0]), 32'h85);
    step();
    settle();
    check("route pass", pcount[0], 32'h0001_0000);

    // streaming, classes 0..3 twice
    pulse_reset();
    for (int i = 0; i < 8; i++) begin
      d = {i[1:0], 6'(i + 5)};
      data_in = d; valid_in = 1'b1;
      settle();
      check("stream ready", 32'(rdy[0]), 32'd1);
      if (i > 0) check("stream wr_en", 32'(wr_en[0]), 32'(4'b0001 << ((i - 1) % 4)));
      step();
    end
    valid_in = 1'b0;
    step();
    settle();
    check("stream pass", pcount[0], 32'h0202_0202);

    // stall on full queue 1
    fifo_full = 4'b0010; data_in = 8'h4A; valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      check("stall wr_en", 32'(wr_en[0]), 32'd0);
      check("stall ready", 32'(rdy[0]), 32'd0);
      step();
    end
    fifo_full = 4'b0000;
    settle();
    check("unstall wr_en", 32'(wr_en[0]), 32'h2);
    check("unstall data", 32'(fdata[0]), 32'h4A);
    check("unstall ready", 32'(rdy[0]), 32'd1);
    step();
    settle();
    check("unstall once", 32'(wr_en[0]), 32'd0);
    check("unstall pass", pcount[0], 32'h0202_0302);
    check("drop variant pass", pcount[1], 32'h0202_0202);
    check("drop variant drop", 32'(dcount[1]), 32'd1);

    // drop on full queue 3
    pulse_reset();
    fifo_full = 4'b1000; data_in = 8'hC0; valid_in = 1'b1;
    step();
    data_in = 8'h01;
    settle();
    check("drop held wr_en", 32'(wr_en[1]), 32'd0);
    check("drop stall ready", 32'(rdy[0]), 32'd0);
    step();
    valid_in = 1'b0;
    settle();
    check("drop count", 32'(dcount[1]), 32'd1);
    check("drop next wr_en", 32'(wr_en[1]), 32'h1);
    check("drop next data", 32'(fdata[1]), 32'h01);
    step();
    settle();
    check("drop next pass", pcount[1], 32'h0000_0001);
    fifo_full = 4'b0000;
    step();
    step();

    // reset while a stalled word is held
    fifo_full = 4'b0010; data_in = 8'h4A; valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    step();
    settle();
    check("pre-reset stalled", 32'(rdy[0]), 32'd0);
    reset = 1'b1; fifo_full = 4'b0000;
    settle();
    check("mid reset ready", 32'(rdy[0]), 32'd0);
    check("mid reset wr_en", 32'(wr_en[0]), 32'd0);
    step();
    reset = 1'b0;
    settle();
    check("after reset ready", 32'(rdy[0]), 32'd1);
    check("after reset wr_en", 32'(wr_en[0]), 32'd0);
    check("after reset pass", pcount[0], 32'h0);
    check("after reset drop", 32'(dcount[1]), 32'd0);

    // pass counter saturation
    for (int i = 0; i < 300; i++) begin
      data_in = {2'b00, 6'(i)}; valid_in = 1'b1;
      step();
    end
    valid_in = 1'b0;
    step();
    settle();
    check("sat pass stall", pcount[0], 32'h0000_00FF);
    check("sat pass drop", pcount[1], 32'h0000_00FF);

    // drop counter saturation
    pulse_reset();
    fifo_full = 4'b0001;
    for (int i = 0; i < 300; i++) begin
      data_in = {2'b00, 6'(i)}; valid_in = 1'b1;
      step();
    end
    valid_in = 1'b0;
    step();
    settle();
    check("sat drop", 32'(dcount[1]), 32'd255);
    check("sat drop pass", pcount[1], 32'h0);
    fifo_full = 4'b0000;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
